// File: rtl/axis2sgdma_ic.sv
// AXI-Stream router to scatter-gather DMA S2MM bridge: forwards data beats unchanged,
// counts bytes per packet and emits a 5-word status/app stream after each packet.
module axis2sgdma_ic #(
  parameter int DATA_TDATA_WIDTH = 64,
  parameter int STS_TDATA_WIDTH  = 32,
  parameter int TID_WIDTH        = 4,
  parameter int LEN_WIDTH        = 26
) (
  input  logic                            clk,
  input  logic                            arstn,
  input  logic [DATA_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [TID_WIDTH-1:0]            s_axis_tid,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [DATA_TDATA_WIDTH-1:0]     data_tdata,
  output logic [DATA_TDATA_WIDTH/8-1:0]   data_tkeep,
  output logic                            data_tlast,
  output logic                            data_tvalid,
  input  logic                            data_tready,
  output logic [STS_TDATA_WIDTH-1:0]      sts_tdata,
  output logic [STS_TDATA_WIDTH/8-1:0]    sts_tkeep,
  output logic                            sts_tlast,
  output logic                            sts_tvalid,
  input  logic                            sts_tready
);

  localparam int KEEP_W = DATA_TDATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(KEEP_W + 1);
  // Wide enough for a 32-bit count plus a 64-byte beat, so saturation is exact.
  localparam int SUM_W  = 34;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;
  localparam logic [2:0] LAST_WIDX = 3'd4;

  typedef enum logic {PASS, STATUS} state_e;

  state_e                state_q, state_d;
  logic                  first_q, first_d;
  logic [LEN_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [TID_WIDTH-1:0]  src_q, src_d;
  logic [2:0]            widx_q, widx_d;

  logic                  hs;
  logic                  sts_hs;
  logic [CNT_W-1:0]      beat_bytes;
  logic [SUM_W-1:0]      sum_ext;
  logic [LEN_WIDTH-1:0]  sum_sat;

  assign hs     = s_axis_tvalid & s_axis_tready;
  assign sts_hs = sts_tvalid & sts_tready;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      beat_bytes = beat_bytes + CNT_W'(s_axis_tkeep[i]);
    end
  end

  assign sum_ext = SUM_W'(byte_cnt_q) + SUM_W'(beat_bytes);
  assign sum_sat = (sum_ext > SUM_W'(LEN_MAX)) ? LEN_MAX : sum_ext[LEN_WIDTH-1:0];

  // NOTE: reset is sampled on the clock edge (synchronous); state uses non-blocking
  // assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q    <= PASS;
      first_q    <= 1'b1;
      byte_cnt_q <= '0;
      len_q      <= '0;
      src_q      <= '0;
      widx_q     <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      src_q      <= src_d;
      widx_q     <= widx_d;
    end
  end

  // NOTE: every combinational output is given a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    src_d      = src_q;
    widx_d     = widx_q;
    case (state_q)
      PASS: begin
        if (hs) begin
          byte_cnt_d = sum_sat;
          if (first_q) begin
            src_d   = s_axis_tid;
            first_d = 1'b0;
          end
          if (s_axis_tlast) begin
            len_d      = sum_sat;
            byte_cnt_d = '0;
            first_d    = 1'b1;
            widx_d     = '0;
            state_d    = STATUS;
          end
        end
      end
      STATUS: begin
        if (sts_hs) begin
          if (widx_q == LAST_WIDX) begin
            widx_d  = '0;
            state_d = PASS;
          end else begin
            widx_d = widx_q + 3'd1;
          end
        end
      end
      default: state_d = PASS;
    endcase
  end

  // Outputs are forced idle while reset is asserted, before the first clock edge too.
  always_comb begin
    data_tdata    = s_axis_tdata;
    data_tkeep    = s_axis_tkeep;
    data_tlast    = s_axis_tlast;
    data_tvalid   = s_axis_tvalid & (state_q == PASS) & arstn;
    s_axis_tready = data_tready & (state_q == PASS) & arstn;
    sts_tvalid    = (state_q == STATUS) & arstn;
    sts_tlast     = (widx_q == LAST_WIDX);
    sts_tkeep     = '1;
    case (widx_q)
      3'd0:    sts_tdata = STS_TDATA_WIDTH'(32'h5000_0000);
      3'd1:    sts_tdata = STS_TDATA_WIDTH'(src_q);
      3'd4:    sts_tdata = STS_TDATA_WIDTH'(len_q);
      default: sts_tdata = '0;
    endcase
  end

endmodule

// File: tb/tb_axis2sgdma_ic.sv
// Self-checking bench for axis2sgdma_ic: directed scenarios plus randomized packets,
// scored against a packet-level model of the data and status streams.
module tb_axis2sgdma_ic;

  localparam int LEN_W = 26;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic [3:0]  s_axis_tid = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] data_tdata;
  logic [7:0]  data_tkeep;
  logic        data_tlast, data_tvalid;
  logic        data_tready = 1'b1;
  logic [31:0] sts_tdata;
  logic [3:0]  sts_tkeep;
  logic        sts_tlast, sts_tvalid;
  logic        sts_tready = 1'b1;

  logic [63:0] t4_tdata = '0;
  logic [7:0]  t4_tkeep = '0;
  logic [3:0]  t4_tid = '0;
  logic        t4_tlast = 1'b0, t4_tvalid = 1'b0, t4_s_tready;
  logic [63:0] t4_data_tdata;
  logic [7:0]  t4_data_tkeep;
  logic        t4_data_tlast, t4_data_tvalid;
  logic        t4_data_tready = 1'b1;
  logic [31:0] t4_sts_tdata;
  logic [3:0]  t4_sts_tkeep;
  logic        t4_sts_tlast, t4_sts_tvalid;
  logic        t4_sts_tready = 1'b1;

  always #5 clk = ~clk;

  axis2sgdma_ic #(.DATA_TDATA_WIDTH(64), .STS_TDATA_WIDTH(32), .TID_WIDTH(4), .LEN_WIDTH(LEN_W)) dut (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tid(s_axis_tid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .data_tdata(data_tdata), .data_tkeep(data_tkeep), .data_tlast(data_tlast),
    .data_tvalid(data_tvalid), .data_tready(data_tready),
    .sts_tdata(sts_tdata), .sts_tkeep(sts_tkeep), .sts_tlast(sts_tlast),
    .sts_tvalid(sts_tvalid), .sts_tready(sts_tready)
  );

  axis2sgdma_ic #(.DATA_TDATA_WIDTH(64), .STS_TDATA_WIDTH(32), .TID_WIDTH(4), .LEN_WIDTH(4)) dut4 (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(t4_tdata), .s_axis_tkeep(t4_tkeep), .s_axis_tid(t4_tid),
    .s_axis_tlast(t4_tlast), .s_axis_tvalid(t4_tvalid), .s_axis_tready(t4_s_tready),
    .data_tdata(t4_data_tdata), .data_tkeep(t4_data_tkeep), .data_tlast(t4_data_tlast),
    .data_tvalid(t4_data_tvalid), .data_tready(t4_data_tready),
    .sts_tdata(t4_sts_tdata), .sts_tkeep(t4_sts_tkeep), .sts_tlast(t4_sts_tlast),
    .sts_tvalid(t4_sts_tvalid), .sts_tready(t4_sts_tready)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } sts_t;

  int errors = 0;
  int checks = 0;

  beat_t      exp_data[$];
  sts_t       exp_sts[$];
  logic [7:0] pk_keep[$];
  logic [3:0] pk_tid[$];
  beat_t      mon_beat;
  sts_t       mon_sts;

  // Scoreboard: every accepted output beat/word is matched against the model queues.
  always @(negedge clk) begin
    if (data_tvalid && data_tready) begin
      checks++;
      if (exp_data.size() == 0) begin
        errors++;
        $display("FAIL data_unexpected: got data=%h keep=%h last=%b, expected no beat",
                 data_tdata, data_tkeep, data_tlast);
      end else begin
        mon_beat = exp_data.pop_front();
        if (data_tdata !== mon_beat.data || data_tkeep !== mon_beat.keep ||
            data_tlast !== mon_beat.last) begin
          errors++;
          $display("FAIL data_beat: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                   data_tdata, data_tkeep, data_tlast, mon_beat.data, mon_beat.keep, mon_beat.last);
        end
      end
    end
    if (sts_tvalid && sts_tready) begin
      checks++;
      if (exp_sts.size() == 0) begin
        errors++;
        $display("FAIL sts_unexpected: got word=%h last=%b, expected no word", sts_tdata, sts_tlast);
      end else begin
        mon_sts = exp_sts.pop_front();
        if (sts_tdata !== mon_sts.data || sts_tlast !== mon_sts.last || sts_tkeep !== 4'hF) begin
          errors++;
          $display("FAIL sts_word: got word=%h last=%b keep=%h, expected word=%h last=%b keep=f",
                   sts_tdata, sts_tlast, sts_tkeep, mon_sts.data, mon_sts.last);
        end
      end
    end
  end

  task automatic apply_ready(input int mode);
    case (mode)
      1: data_tready = ~data_tready;
      2: begin
        data_tready = ($urandom_range(0, 3) != 0);
        sts_tready  = ($urandom_range(0, 2) != 0);
      end
      default: ;
    endcase
  endtask

  // Drives the first nsend beats of the packet in pk_keep/pk_tid; a packet with all
  // beats sent also queues its expected status sequence.
  task automatic drive_pkt(input int nsend, input int mode);
    int total = pk_keep.size();
    longint bytes = 0;
    logic [3:0] src = pk_tid[0];
    beat_t bt;
    for (int b = 0; b < nsend; b++) begin
      int  waited = 0;
      bit  got = 0;
      bt.data = {$urandom, $urandom};
      bt.keep = pk_keep[b];
      bt.last = (b == total - 1);
      bytes += $countones(pk_keep[b]);
      exp_data.push_back(bt);
      s_axis_tdata  = bt.data;
      s_axis_tkeep  = bt.keep;
      s_axis_tlast  = bt.last;
      s_axis_tid    = pk_tid[b];
      s_axis_tvalid = 1'b1;
      while (!got) begin
        @(negedge clk);
        got = s_axis_tvalid && s_axis_tready;
        if (mode == 1) begin
          checks++;
          if (s_axis_tready !== data_tready) begin
            errors++;
            $display("FAIL tready_mirror: got s_axis_tready=%b, expected %b", s_axis_tready, data_tready);
          end
        end
        @(posedge clk);
        #1;
        apply_ready(mode);
        waited++;
        if (!got && waited > 200) begin
          checks++;
          errors++;
          $display("FAIL beat_timeout: beat %0d not accepted after %0d cycles, expected acceptance", b, waited);
          break;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (nsend == total) begin
      if (bytes > (64'd1 << LEN_W) - 1) bytes = (64'd1 << LEN_W) - 1;
      exp_sts.push_back('{32'h5000_0000, 1'b0});
      exp_sts.push_back('{{28'd0, src}, 1'b0});
      exp_sts.push_back('{32'd0, 1'b0});
      exp_sts.push_back('{32'd0, 1'b0});
      exp_sts.push_back('{32'(bytes), 1'b1});
    end
  endtask

  task automatic set_pkt(input int n, input logic [7:0] keep, input logic [3:0] tid);
    pk_keep.delete();
    pk_tid.delete();
    for (int i = 0; i < n; i++) begin
      pk_keep.push_back(keep);
      pk_tid.push_back(tid);
    end
  endtask

  task automatic drain_and_check(input string name);
    data_tready = 1'b1;
    sts_tready  = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (exp_data.size() != 0 || exp_sts.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d beats and %0d status words outstanding, expected 0 and 0",
               name, exp_data.size(), exp_sts.size());
      exp_data.delete();
      exp_sts.delete();
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    s_axis_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0 || data_tvalid !== 1'b0 || sts_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got tready=%b data_tvalid=%b sts_tvalid=%b, expected 0 0 0",
               s_axis_tready, data_tvalid, sts_tvalid);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    arstn = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1 || sts_tvalid !== 1'b0 || sts_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got tready=%b sts_tvalid=%b sts_tlast=%b, expected 1 0 0",
               s_axis_tready, sts_tvalid, sts_tlast);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_packet();
    set_pkt(3, 8'hFF, 4'd3);
    pk_keep[2] = 8'h0F;
    drive_pkt(3, 0);
    drain_and_check("single_packet");
  endtask

  task automatic test_backpressure();
    set_pkt(8, 8'hFF, 4'd5);
    data_tready = 1'b1;
    drive_pkt(8, 1);
    drain_and_check("backpressure");
  endtask

  task automatic test_status_stall();
    sts_tready = 1'b0;
    set_pkt(2, 8'hFF, 4'd10);
    pk_keep[1] = 8'h03;
    drive_pkt(2, 0);
    set_pkt(3, 8'h3C, 4'd9);
    fork
      drive_pkt(3, 0);
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          checks++;
          if (sts_tvalid !== 1'b1 || sts_tdata !== 32'h5000_0000 || s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got sts_tvalid=%b word=%h tready=%b, expected 1 50000000 0",
                     c, sts_tvalid, sts_tdata, s_axis_tready);
          end
        end
        @(posedge clk);
        #1;
        sts_tready = 1'b1;
      end
    join
    drain_and_check("status_stall");
  endtask

  task automatic test_tid_change();
    set_pkt(3, 8'hFF, 4'd7);
    pk_tid[0] = 4'd1;
    drive_pkt(3, 0);
    drain_and_check("tid_change");
  endtask

  task automatic test_reset_mid_packet();
    set_pkt(4, 8'hFF, 4'd4);
    drive_pkt(2, 0);
    arstn = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0 || sts_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got tready=%b sts_tvalid=%b, expected 0 0", s_axis_tready, sts_tvalid);
    end
    @(posedge clk);
    #1;
    arstn = 1'b1;
    set_pkt(1, 8'h01, 4'd2);
    drive_pkt(1, 0);
    drain_and_check("reset_mid_packet");
  endtask

  task automatic test_saturation();
    sts_t got_q[$];
    for (int b = 0; b < 3; b++) begin
      int waited = 0;
      bit got = 0;
      t4_tdata  = {$urandom, $urandom};
      t4_tkeep  = 8'hFF;
      t4_tid    = 4'd6;
      t4_tlast  = (b == 2);
      t4_tvalid = 1'b1;
      while (!got) begin
        @(negedge clk);
        got = t4_s_tready;
        @(posedge clk);
        #1;
        waited++;
        if (!got && waited > 50) begin
          checks++;
          errors++;
          $display("FAIL sat_timeout: beat %0d not accepted, expected acceptance", b);
          break;
        end
      end
    end
    t4_tvalid = 1'b0;
    t4_tlast  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (t4_sts_tvalid && t4_sts_tready) got_q.push_back('{t4_sts_tdata, t4_sts_tlast});
    end
    @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL sat_count: got %0d status words, expected 5", got_q.size());
    end else begin
      checks++;
      if (got_q[0].data !== 32'h5000_0000 || got_q[1].data !== 32'd6 ||
          got_q[4].data !== 32'd15 || got_q[4].last !== 1'b1) begin
        errors++;
        $display("FAIL sat_words: got w0=%h w1=%h w4=%h last=%b, expected 50000000 6 f 1",
                 got_q[0].data, got_q[1].data, got_q[4].data, got_q[4].last);
      end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 15; p++) begin
      int n = $urandom_range(1, 6);
      pk_keep.delete();
      pk_tid.delete();
      for (int b = 0; b < n; b++) begin
        pk_keep.push_back(($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom));
        pk_tid.push_back(4'($urandom));
      end
      drive_pkt(n, 2);
    end
    drain_and_check("random");
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 4; p++) begin
      set_pkt(1, 8'($urandom), 4'(p + 11));
      drive_pkt(1, 0);
    end
    drain_and_check("back_to_back");
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_status_stall();
    test_tid_change();
    test_reset_mid_packet();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
